barrett_reduce_pipe: RTL

Pipelined, parametrised Barrett modular reducer: computes `in_data mod Q` for any odd modulus Q and a product-width input. It carries a caller tag alongside each operand and uses a valid/ready handshake with backpressure. It sits after the coefficient multipliers in the NTT/polynomial datapath and replaces the single-modulus combinational reducers. Throughput is one operand per cycle; latency is 3 cycles.

---
 rtl/barrett_pkg.sv | 32 +++
 rtl/barrett_cond_sub.sv | 22 ++
 rtl/barrett_reduce_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/barrett_pkg.sv
// barrett_pkg: shared constants and elaboration helpers for the Barrett
// reducers in the NTT datapath.
//   barrett_mu(q, qw)     : floor(2^(2*qw) / q)
//   barrett_s1_w(in_w,qw) : width of the full S1 product (a >> qw) * MU
//   barrett_cfg_ok(...)   : legality of a Q / QW / IN_W / TAG_W combination
package barrett_pkg;

  localparam int unsigned BARRETT_STAGES = 3;
  localparam int unsigned BARRETT_DEF_Q  = 2909;
  localparam int unsigned BARRETT_DEF_QW = 12;

  function automatic longint unsigned barrett_mu(input longint unsigned q,
                                                 input int unsigned     qw);
    return (64'd1 << (2 * qw)) / q;
  endfunction

  // (a >> qw) is in_w-qw bits wide and MU is qw+1 bits wide.
  function automatic int unsigned barrett_s1_w(input int unsigned in_w,
                                               input int unsigned qw);
    return (in_w - qw) + qw + 1;
  endfunction

  function automatic bit barrett_cfg_ok(input longint unsigned q,
                                        input int unsigned     qw,
                                        input int unsigned     in_w,
                                        input int unsigned     tag_w);
    return (qw >= 2) && (qw <= 30) &&
           (q > (64'd1 << (qw - 1))) && (q < (64'd1 << qw)) && q[0] &&
           (in_w >= qw + 1) && (in_w <= 2 * qw) && (tag_w >= 1);
  endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// barrett_cond_sub: final Barrett correction. Takes a raw remainder known to
// lie in [0, 3Q) and returns it reduced into [0, Q).
//   r_i : QW+2-bit raw remainder
//   r_o : QW-bit reduced result
module barrett_cond_sub #(
  parameter int unsigned Q  = 2909,
  parameter int unsigned QW = 12
) (
  input  logic [QW+1:0] r_i,
  output logic [QW-1:0] r_o
);

  localparam logic [QW+1:0] Q1 = (QW+2)'(Q);
  localparam logic [QW+1:0] Q2 = (QW+2)'(2 * Q);

  always_comb begin
    r_o = QW'(r_i);
    if (r_i >= Q2)      r_o = QW'(r_i - Q2);
    else if (r_i >= Q1) r_o = QW'(r_i - Q1);
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: 3-stage pipelined Barrett reducer, out = in mod Q,
// with a tag carried alongside and a global-stall valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (in_ready = !out_valid | out_ready)
//   in_data, in_tag      : operand (IN_W bits, unsigned) and sideband tag
//   out_valid/out_ready  : result handshake
//   out_data, out_tag    : in_data mod Q in [0, Q), and the operand's tag
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int unsigned Q     = BARRETT_DEF_Q,
  parameter int unsigned QW    = BARRETT_DEF_QW,
  parameter int unsigned IN_W  = 2 * QW - 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (!barrett_cfg_ok(Q, QW, IN_W, TAG_W)) begin : g_cfg_err
    $error("barrett_reduce_pipe: illegal Q/QW/IN_W/TAG_W combination");
  end

  localparam int unsigned P1_W = barrett_s1_w(IN_W, QW);
  localparam int unsigned Q3_W = P1_W - QW;   // width of q2 >> QW
  localparam int unsigned RW   = QW + 2;      // raw remainder, exact for [0, 3Q)
  localparam int unsigned PW   = Q3_W + QW;   // full width of q3 * Q
  localparam logic [P1_W-1:0] MU = P1_W'(barrett_mu(Q, QW));

  logic                        adv;
  logic [BARRETT_STAGES:1]     vld_q;
  logic [Q3_W-1:0]             q3_d, q3_q;
  logic [RW-1:0]               a1_q;
  logic [RW-1:0]               r_raw_d, r_raw_q;
  logic [QW-1:0]               r_fix, data3_q;
  logic [TAG_W-1:0]            tag1_q, tag2_q, tag3_q;

  // Global stall: every stage moves together whenever the output slot frees.
  assign adv      = !vld_q[BARRETT_STAGES] || out_ready;
  assign in_ready = adv;

  // S1 product is formed at full precision; only q2 >> QW is ever consumed,
  // so the shifted value is what gets registered.
  assign q3_d = Q3_W'((P1_W'(in_data[IN_W-1:QW]) * MU) >> QW);

  // The true remainder is below 3Q < 2^RW, so working mod 2^RW is exact and
  // only the low RW bits of a need to travel with the operand.
  assign r_raw_d = RW'(PW'(a1_q) - PW'(q3_q) * PW'(Q));

  barrett_cond_sub #(.Q(Q), .QW(QW)) u_fix (
    .r_i (r_raw_q),
    .r_o (r_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      q3_q    <= '0;
      a1_q    <= '0;
      tag1_q  <= '0;
      r_raw_q <= '0;
      tag2_q  <= '0;
      data3_q <= '0;
      tag3_q  <= '0;
    end else if (adv) begin
      // in_ready == adv here, so in_valid alone is the S1 accept.
      vld_q   <= {vld_q[BARRETT_STAGES-1:1], in_valid};
      q3_q    <= q3_d;
      a1_q    <= RW'(in_data);
      tag1_q  <= in_tag;
      r_raw_q <= r_raw_d;
      tag2_q  <= tag1_q;
      data3_q <= r_fix;
      tag3_q  <= tag2_q;
    end
  end

  assign out_valid = vld_q[BARRETT_STAGES];
  assign out_data  = data3_q;
  assign out_tag   = tag3_q;

endmodule
